// File: rtl/operand_fetch_pkg.sv
// Shared datapath constants, state encoding and small helpers for the
// operand fetch front end of the 8-bit RISC datapath.
package operand_fetch_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int OP_W   = 4;

  // ALU opcodes; this block only carries them through unmodified.
  localparam logic [OP_W-1:0] OP_ADD = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [OP_W-1:0] OP_AND = 4'h2;
  localparam logic [OP_W-1:0] OP_OR  = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR = 4'h4;
  localparam logic [OP_W-1:0] OP_SHL = 4'h5;
  localparam logic [OP_W-1:0] OP_SHR = 4'h6;
  localparam logic [OP_W-1:0] OP_MOV = 4'h7;

  // State encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD_A  = 3'd1;
  localparam logic [2:0] ST_RD_B  = 3'd2;
  localparam logic [2:0] ST_CAP_B = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    RD_A  = ST_RD_A,
    RD_B  = ST_RD_B,
    CAP_B = ST_CAP_B,
    OUT   = ST_OUT
  } state_e;

  // Decoded instruction as held for the duration of one fetch.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic              use_imm;
    logic [DATA_W-1:0] imm;
  } instr_t;

  // True when the writeback port is updating register src this cycle.
  function automatic logic wb_hit(input logic              wb_valid,
                                  input logic [ADDR_W-1:0] wb_addr,
                                  input logic [ADDR_W-1:0] src);
    return wb_valid && (wb_addr == src);
  endfunction

endpackage

// File: rtl/fetch_bypass_mux.sv
// Per-operand writeback bypass. The register bank returns old data on a
// read-during-write, so a write landing in the issue cycle is remembered
// here and a write landing in the capture cycle is taken live.
module fetch_bypass_mux
  import operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic [DATA_W-1:0] data_o
);

  logic              hit;
  logic              fwd_valid_q;
  logic [DATA_W-1:0] fwd_data_q;

  assign hit = wb_hit(wb_valid_i, wb_addr_i, src_addr_i);

  // Remember a same-cycle write seen while the read is being issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_valid_q <= 1'b0;
      fwd_data_q  <= '0;
    end else if (issue_i) begin
      fwd_valid_q <= hit;
      if (hit) begin
        fwd_data_q <= wb_data_i;
      end
    end
  end

  // Newest value wins: live writeback, then latched writeback, then bank.
  always_comb begin
    data_o = rf_data_i;
    if (hit) begin
      data_o = wb_data_i;
    end else if (fwd_valid_q) begin
      data_o = fwd_data_q;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: accepts one decoded instruction, reads both sources through
// the single synchronous register-bank read port with writeback bypass, and
// presents the operand pair to the ALU.
//
// state | meaning
// IDLE  | no instruction held, ready to accept
// RD_A  | read of rs1 issued to the bank
// RD_B  | capture A; read of rs2 issued (or immediate taken as B)
// CAP_B | capture B
// OUT   | operands presented to the ALU, held until consumed
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,

  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic              instr_use_imm,
  input  logic [DATA_W-1:0] instr_imm,

  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,

  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,

  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [ADDR_W-1:0] alu_rd
);

  state_e            state_q, state_d;
  instr_t            instr_q;
  logic              accept;
  logic              alu_fire;

  logic              rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_W-1:0] rf_rd_addr_q, rf_rd_addr_d;

  logic              alu_valid_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [ADDR_W-1:0] alu_rd_q;

  logic              issue_a, issue_b;
  logic [DATA_W-1:0] byp_a, byp_b;
  logic              enter_out;

  // Ready is combinational from alu_ready so a consumed result and the next
  // instruction can be exchanged on the same edge.
  assign alu_fire    = (state_q == OUT) && alu_ready;
  assign instr_ready = (state_q == IDLE) || alu_fire;
  assign accept      = instr_valid && instr_ready;

  // The bank read is issued in RD_A for A and in RD_B for B.
  assign issue_a   = (state_q == RD_A);
  assign issue_b   = (state_q == RD_B) && !instr_q.use_imm;
  assign enter_out = (state_d == OUT) && (state_q != OUT);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next read-port strobe/address. The read port is
  // registered, so the strobe is set on the edge entering the issue state.
  always_comb begin
    state_d      = state_q;
    rf_rd_en_d   = 1'b0;
    rf_rd_addr_d = rf_rd_addr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = RD_A;
          rf_rd_en_d   = 1'b1;
          rf_rd_addr_d = instr_rs1;
        end
      end
      RD_A: begin
        state_d = RD_B;
        if (!instr_q.use_imm) begin
          rf_rd_en_d   = 1'b1;
          rf_rd_addr_d = instr_q.rs2;
        end
      end
      RD_B: begin
        state_d = instr_q.use_imm ? OUT : CAP_B;
      end
      CAP_B: begin
        state_d = OUT;
      end
      OUT: begin
        if (accept) begin
          state_d      = RD_A;
          rf_rd_en_d   = 1'b1;
          rf_rd_addr_d = instr_rs1;
        end else if (alu_fire) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Hold the accepted instruction for the whole fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
    end else if (accept) begin
      instr_q.op      <= instr_op;
      instr_q.rs1     <= instr_rs1;
      instr_q.rs2     <= instr_rs2;
      instr_q.rd      <= instr_rd;
      instr_q.use_imm <= instr_use_imm;
      instr_q.imm     <= instr_imm;
    end
  end

  // Register-bank read port; the address holds when no read is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_rd_en_q   <= 1'b0;
      rf_rd_addr_q <= '0;
    end else begin
      rf_rd_en_q   <= rf_rd_en_d;
      rf_rd_addr_q <= rf_rd_addr_d;
    end
  end

  fetch_bypass_mux u_byp_a (
    .clk        (clk),
    .reset      (reset),
    .issue_i    (issue_a),
    .src_addr_i (instr_q.rs1),
    .wb_valid_i (wb_valid),
    .wb_addr_i  (wb_addr),
    .wb_data_i  (wb_data),
    .rf_data_i  (rf_rd_data),
    .data_o     (byp_a)
  );

  fetch_bypass_mux u_byp_b (
    .clk        (clk),
    .reset      (reset),
    .issue_i    (issue_b),
    .src_addr_i (instr_q.rs2),
    .wb_valid_i (wb_valid),
    .wb_addr_i  (wb_addr),
    .wb_data_i  (wb_data),
    .rf_data_i  (rf_rd_data),
    .data_o     (byp_b)
  );

  // Operand capture and ALU-side outputs; nothing changes while in OUT, so
  // late writebacks cannot disturb operands already presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_valid_q <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_rd_q    <= '0;
    end else begin
      alu_valid_q <= (state_d == OUT);
      if (state_q == RD_B) begin
        alu_a_q <= byp_a;
        if (instr_q.use_imm) begin
          alu_b_q <= instr_q.imm;
        end
      end
      if (state_q == CAP_B) begin
        alu_b_q <= byp_b;
      end
      if (enter_out) begin
        alu_op_q <= instr_q.op;
        alu_rd_q <= instr_q.rd;
      end
    end
  end

  assign rf_rd_en   = rf_rd_en_q;
  assign rf_rd_addr = rf_rd_addr_q;
  assign alu_valid  = alu_valid_q;
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_rd     = alu_rd_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios followed by random traffic,
// all checked against a cycle-level model of the architectural register file.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              instr_valid;
  logic              instr_ready;
  logic [OP_W-1:0]   instr_op;
  logic [ADDR_W-1:0] instr_rs1;
  logic [ADDR_W-1:0] instr_rs2;
  logic [ADDR_W-1:0] instr_rd;
  logic              instr_use_imm;
  logic [DATA_W-1:0] instr_imm;
  logic              rf_rd_en;
  logic [ADDR_W-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              alu_valid;
  logic              alu_ready;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [ADDR_W-1:0] alu_rd;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_op      (instr_op),
    .instr_rs1     (instr_rs1),
    .instr_rs2     (instr_rs2),
    .instr_rd      (instr_rd),
    .instr_use_imm (instr_use_imm),
    .instr_imm     (instr_imm),
    .rf_rd_en      (rf_rd_en),
    .rf_rd_addr    (rf_rd_addr),
    .rf_rd_data    (rf_rd_data),
    .wb_valid      (wb_valid),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_op        (alu_op),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_rd        (alu_rd)
  );

  // Register bank: synchronous read, read-during-write returns old data.
  logic [DATA_W-1:0] mem [0:7];
  always @(posedge clk) begin
    if (rf_rd_en) rf_rd_data <= mem[rf_rd_addr];
    if (wb_valid) mem[wb_addr] <= wb_data;
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc   = 0;
  bit pend  = 1'b0;
  bit vld   = 1'b0;
  logic [OP_W-1:0]   m_op;
  logic [ADDR_W-1:0] m_rs1, m_rs2, m_rd;
  bit                m_ui;
  logic [DATA_W-1:0] m_imm, exp_a, exp_b, last_a, last_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Operands are the register contents as they stand after the write in the
  // capture cycle; output timing follows the fixed 3/2-cycle latency.
  task automatic observe();
    bit en;
    if (pend && cyc == acc + 3) begin
      exp_a = mem[m_rs1];
      if (m_ui) exp_b = m_imm;
    end
    if (pend && !m_ui && cyc == acc + 4) exp_b = mem[m_rs2];
    vld = pend && (cyc >= acc + (m_ui ? 3 : 4));
    check_eq("alu_valid", 32'(alu_valid), 32'(vld));
    if (vld) begin
      check_eq("alu_a", 32'(alu_a), 32'(exp_a));
      check_eq("alu_b", 32'(alu_b), 32'(exp_b));
      check_eq("alu_op", 32'(alu_op), 32'(m_op));
      check_eq("alu_rd", 32'(alu_rd), 32'(m_rd));
      last_a = alu_a;
      last_b = alu_b;
    end
    en = pend && (cyc == acc + 1 || (cyc == acc + 2 && !m_ui));
    check_eq("rf_rd_en", 32'(rf_rd_en), 32'(en));
    if (en) check_eq("rf_rd_addr", 32'(rf_rd_addr), 32'((cyc == acc + 1) ? m_rs1 : m_rs2));
  endtask

  // Commit the inputs driven this cycle across the next edge.
  task automatic step();
    bit rdy;
    #1;
    rdy = !pend || (vld && alu_ready);
    check_eq("instr_ready", 32'(instr_ready), 32'(rdy));
    if (pend && vld && alu_ready) pend = 1'b0;
    if (instr_valid && rdy) begin
      pend = 1'b1; acc = cyc;
      m_op = instr_op; m_rs1 = instr_rs1; m_rs2 = instr_rs2; m_rd = instr_rd;
      m_ui = instr_use_imm; m_imm = instr_imm;
    end
    @(negedge clk);
    cyc++;
    observe();
  endtask

  task automatic idle_in();
    instr_valid = 1'b0; wb_valid = 1'b0; alu_ready = 1'b1;
  endtask

  task automatic set_instr(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] rs1,
                           input logic [ADDR_W-1:0] rs2, input logic [ADDR_W-1:0] rd,
                           input bit ui, input logic [DATA_W-1:0] imm);
    instr_valid = 1'b1; instr_op = op; instr_rs1 = rs1; instr_rs2 = rs2;
    instr_rd = rd; instr_use_imm = ui; instr_imm = imm;
  endtask

  task automatic set_wb(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_valid = 1'b1; wb_addr = a; wb_data = d;
  endtask

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, "_alu_valid"}, 32'(alu_valid), 32'd0);
    check_eq({pfx, "_alu_op"}, 32'(alu_op), 32'd0);
    check_eq({pfx, "_alu_a"}, 32'(alu_a), 32'd0);
    check_eq({pfx, "_alu_b"}, 32'(alu_b), 32'd0);
    check_eq({pfx, "_alu_rd"}, 32'(alu_rd), 32'd0);
    check_eq({pfx, "_rf_rd_en"}, 32'(rf_rd_en), 32'd0);
    check_eq({pfx, "_rf_rd_addr"}, 32'(rf_rd_addr), 32'd0);
    check_eq({pfx, "_instr_ready"}, 32'(instr_ready), 32'd1);
  endtask

  // One instruction from idle; optional writes to rs2 in its issue (w2) and
  // capture (w3) cycles; bounded drain.
  task automatic run_instr(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] rs1,
                           input logic [ADDR_W-1:0] rs2, input logic [ADDR_W-1:0] rd,
                           input bit ui, input logic [DATA_W-1:0] imm,
                           input bit w2, input logic [DATA_W-1:0] d2,
                           input bit w3, input logic [DATA_W-1:0] d3);
    last_a = '0; last_b = '0;
    idle_in(); set_instr(op, rs1, rs2, rd, ui, imm); step();
    for (int r = 1; r < 12 && pend; r++) begin
      idle_in();
      if (r == 2 && w2) set_wb(rs2, d2);
      if (r == 3 && w3) set_wb(rs2, d3);
      step();
    end
    check_eq("drain_timeout", 32'(pend), 32'd0);
  endtask

  logic [31:0] rnd, rnd2;
  logic [DATA_W-1:0] preload [0:7];

  initial begin
    reset = 1'b1;
    idle_in();
    set_instr('0, '0, '0, '0, 1'b0, '0);
    instr_valid = 1'b0;
    wb_addr = '0; wb_data = '0;
    @(negedge clk); @(negedge clk);
    check_reset_state("init");
    reset = 1'b0;
    cyc = 0;
    observe();

    preload[0] = 8'h5A; preload[1] = 8'h12; preload[2] = 8'h34; preload[3] = 8'hC3;
    preload[4] = 8'h3C; preload[5] = 8'hA0; preload[6] = 8'h99; preload[7] = 8'hE7;
    for (int i = 0; i < 8; i++) begin
      idle_in(); set_wb(3'(i), preload[i]); step();
    end

    // Register-register read.
    run_instr(4'h1, 3'd1, 3'd2, 3'd3, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    check_eq("rr_a", 32'(last_a), 32'h12);
    check_eq("rr_b", 32'(last_b), 32'h34);

    // Immediate operand.
    run_instr(4'h2, 3'd5, 3'd0, 3'd4, 1'b1, 8'h0F, 1'b0, 8'h00, 1'b0, 8'h00);
    check_eq("imm_a", 32'(last_a), 32'hA0);
    check_eq("imm_b", 32'(last_b), 32'h0F);

    // Forwarding into operand B.
    idle_in(); set_wb(3'd2, 8'h00); step();
    run_instr(4'h3, 3'd1, 3'd2, 3'd3, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 8'h00);
    check_eq("fwd_issue_b", 32'(last_b), 32'h77);
    idle_in(); set_wb(3'd2, 8'h00); step();
    run_instr(4'h3, 3'd1, 3'd2, 3'd3, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h77);
    check_eq("fwd_cap_b", 32'(last_b), 32'h77);
    idle_in(); set_wb(3'd2, 8'h00); step();
    run_instr(4'h3, 3'd1, 3'd2, 3'd3, 1'b0, 8'h00, 1'b1, 8'h55, 1'b1, 8'h66);
    check_eq("fwd_both_b", 32'(last_b), 32'h66);

    // Backpressure in OUT with writes to rs1, then chained accept.
    idle_in(); set_instr(4'h7, 3'd1, 3'd2, 3'd6, 1'b0, 8'h00); step();
    for (int r = 1; r <= 3; r++) begin
      idle_in(); alu_ready = 1'b0; step();
    end
    for (int k = 0; k < 5; k++) begin
      rnd = $urandom();
      idle_in(); alu_ready = 1'b0; set_wb(3'd1, rnd[7:0]);
      set_instr(4'h9, 3'd4, 3'd4, 3'd1, 1'b0, 8'h00);
      step();
    end
    idle_in(); set_instr(4'h2, 3'd4, 3'd4, 3'd1, 1'b0, 8'h00); alu_ready = 1'b1; step();
    check_eq("bp_chain_rd_en", 32'(rf_rd_en), 32'd1);
    check_eq("bp_chain_addr", 32'(rf_rd_addr), 32'd4);
    last_a = '0; last_b = '0;
    for (int r = 0; r < 12 && pend; r++) begin
      idle_in(); step();
    end
    check_eq("bp_drain", 32'(pend), 32'd0);
    check_eq("same_src_a", 32'(last_a), 32'h3C);
    check_eq("same_src_b", 32'(last_b), 32'h3C);

    // Reset while in CAP_B abandons the instruction.
    idle_in(); set_instr(4'h5, 3'd1, 3'd2, 3'd2, 1'b0, 8'h00); step();
    idle_in(); step(); step();
    reset = 1'b1;
    #1;
    check_reset_state("midrst");
    pend = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    cyc += 2;
    observe();
    run_instr(4'h6, 3'd4, 3'd5, 3'd7, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    check_eq("post_rst_a", 32'(last_a), 32'h3C);
    check_eq("post_rst_b", 32'(last_b), 32'hA0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rnd  = $urandom();
      rnd2 = $urandom();
      instr_valid   = rnd[0];
      instr_op      = rnd[4:1];
      instr_rs1     = rnd[7:5];
      instr_rs2     = rnd[10:8];
      instr_rd      = rnd[13:11];
      instr_use_imm = rnd[14] & rnd[15];
      instr_imm     = rnd[23:16];
      wb_valid      = rnd2[0];
      wb_addr       = rnd2[3:1];
      wb_data       = rnd2[11:4];
      alu_ready     = rnd2[12] | rnd2[13];
      step();
    end
    for (int r = 0; r < 12 && pend; r++) begin
      idle_in(); step();
    end
    check_eq("final_drain", 32'(pend), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side front end of the 8-bit RISC datapath. Accepts one decoded instruction at a time over a valid/ready handshake.
- Reads its two source operands through the register bank's single synchronous read port, forwarding any in-flight writeback.
- Presents opcode, operand pair and destination to the ALU over a second valid/ready handshake, completing the write→read loop with the writeback side.

Parameters:
DATA_W, 8, operand/register data width
ADDR_W, 3, register address width (8 registers)
OP_W, 4, ALU opcode width

Ports:
clk  in  1  clock
reset  in  1  reset
instr_valid  in  1  decoded instruction available
instr_ready  out  1  block accepts instruction this cycle
instr_op  in  OP_W  ALU opcode
instr_rs1  in  ADDR_W  source A register
instr_rs2  in  ADDR_W  source B register
instr_rd  in  ADDR_W  destination register (passed through)
instr_use_imm  in  1  1: operand B = instr_imm, rs2 not read
instr_imm  in  DATA_W  immediate
rf_rd_en  out  1  register-bank read strobe
rf_rd_addr  out  ADDR_W  register-bank read address
rf_rd_data  in  DATA_W  read data, valid the cycle after rf_rd_en; read-during-write returns old data
wb_valid  in  1  register-bank write occurring this cycle
wb_addr  in  ADDR_W  write address
wb_data  in  DATA_W  write data
alu_valid  out  1  operands valid
alu_ready  in  1  ALU consumes operands
alu_op  out  OP_W  latched opcode
alu_a  out  DATA_W  operand A
alu_b  out  DATA_W  operand B
alu_rd  out  ADDR_W  latched destination

Behaviour:
- Reset: asynchronous, active-high; clock clk.
  - State IDLE; all registered outputs 0 (alu_valid, alu_op, alu_a, alu_b, alu_rd, rf_rd_en, rf_rd_addr); forward flags cleared.
  - Reset mid-operation abandons the instruction; nothing is emitted.
- States: IDLE, RD_A, RD_B, CAP_B, OUT.
- instr_ready = (state==IDLE) | (state==OUT & alu_ready). This is combinational from alu_ready.
  - Handshake = instr_valid & instr_ready. On handshake, latch op/rs1/rs2/rd/use_imm/imm and go to RD_A.
- RD_A: rf_rd_en=1, rf_rd_addr=rs1 → RD_B.
- RD_B: capture A. If !use_imm: rf_rd_en=1, rf_rd_addr=rs2 → CAP_B. If use_imm: alu_b<=imm → OUT.
- CAP_B: capture B → OUT.
- rf_rd_en=0 in IDLE, CAP_B and OUT; rf_rd_addr holds its last value.
- Operand capture priority, per operand with source address S:
  - (1) wb_valid & wb_addr==S in the capture cycle → wb_data.
  - (2) Else, if wb_valid & wb_addr==S occurred in that operand's issue cycle, use wb_data latched then.
  - (3) Else rf_rd_data.
- OUT: alu_valid=1. alu_op/a/b/rd are held stable until alu_valid & alu_ready.
  - On handshake: if instr_valid, accept the next instruction and go to RD_A. Otherwise go to IDLE with alu_valid=0.
  - Writebacks while in OUT do not modify held operands.
- Latency from instruction-accept edge to alu_valid high: 3 cycles with a register source, 2 with an immediate. Sustained throughput is 1 instruction per 4 cycles (3 with immediate) when alu_ready=1.
- rs1==rs2 is legal: both operands are read independently and each is forwarded independently.
- No arithmetic or width conversion; data passes unmodified.

Decomposition:
- Shared package (datapath pkg): DATA_W/ADDR_W/OP_W constants, opcode localparams, state encoding localparams for IDLE..OUT.
- One natural sub-module: fetch_bypass_mux.
  - Contains the per-operand forward-latch register and the 3-way priority select.
  - Instantiated twice, for A and B.

Test Plan:
- Reg-reg read: RF r1=8'h12, r2=8'h34, instr op=4'h1, rs1=1, rs2=2, rd=3 → alu_valid 3 cycles after accept; a=12, b=34, rd=3. rf_rd_addr sequence 1,2.
- Immediate: r5=8'hA0, rs1=5, use_imm=1, imm=8'h0F → alu_valid 2 cycles after accept; a=A0, b=0F. Only one rf_rd_en pulse.
- Forwarding: r2=8'h00 in RF.
  - wb_valid, wb_addr=2, wb_data=8'h77 in the rs2 issue cycle → b=77.
  - Repeat with the write in the capture cycle → b=77.
  - Writes in both cycles, 8'h55 then 8'h66 → b=66.
- Backpressure: alu_ready=0 for 5 cycles in OUT with wb writing rs1 → alu_a/b/op/rd stable, instr_ready=0. Then alu_ready=1 with instr_valid=1 → next instruction accepted on the same edge, next state RD_A.
- Reset mid-op: assert reset during CAP_B → all outputs 0, state IDLE, no alu_valid pulse. After release, a new instruction completes normally.
- Same source: rs1=rs2=4, r4=8'h3C → a=b=3C.
